// File: rtl/wb_write_arbiter.sv
// Arbitrates the single register-file write port between the W stage and queued MDU results.
// Port selection is combinational, with no added latency. MDU results wait in a FIFO; mdu_ready drops when the FIFO is full.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RegWrite_W,
  input  logic [4:0]             Rd_W,
  input  logic [XLEN-1:0]        Result_W,
  input  logic                   mdu_valid,
  input  logic [4:0]             mdu_rd,
  input  logic [XLEN-1:0]        mdu_data,
  output logic                   mdu_ready,
  output logic [4:0]             A3_W,
  output logic [XLEN-1:0]        WD3_W,
  output logic                   WE3_W,
  output logic [31:0]            busy_mask,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            live;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;

  ent_t head;
  logic w_sel;
  logic empty;
  logic pop;
  logic push;

  always_comb begin
    head  = mem_q[rd_ptr_q];
    w_sel = RegWrite_W && (Rd_W != 5'd0);
    empty = (count_q == '0);
    mdu_ready = rst_n && (count_q < FULL_CNT);
    // A dead head is retired even while the W stage owns the port.
    pop   = !empty && (!w_sel || !head.live);
    push  = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
  end

  always_comb begin
    A3_W  = 5'd0;
    WD3_W = '0;
    WE3_W = 1'b0;
    if (rst_n) begin
      if (w_sel) begin
        A3_W  = Rd_W;
        WD3_W = Result_W;
        WE3_W = 1'b1;
      end else if (!empty) begin
        A3_W  = head.rd;
        WD3_W = head.data;
        WE3_W = head.live;
      end
    end
  end

  always_comb begin
    busy_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].live) busy_mask[mem_q[i].rd] = 1'b1;
    end
  end

  assign fifo_count = count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // The younger W-stage value supersedes any older queued write to the same register.
    if (w_sel) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].rd == Rd_W) mem_d[i].live = 1'b0;
      end
    end
    if (pop) begin
      mem_d[rd_ptr_q].live = 1'b0;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = '{rd: mdu_rd, data: mdu_data, live: 1'b1};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (push && !pop) count_d = count_q + (PW+1)'(1);
    else if (pop && !push) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed and random checks of wb_write_arbiter against a queue-based reference model.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        RegWrite_W;
  logic [4:0]  Rd_W;
  logic [31:0] Result_W;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  A3_W;
  logic [31:0] WD3_W;
  logic        WE3_W;
  logic [31:0] busy_mask;
  logic [2:0]  fifo_count;

  wb_write_arbiter #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_W(RegWrite_W), .Rd_W(Rd_W), .Result_W(Result_W),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .A3_W(A3_W), .WD3_W(WD3_W), .WE3_W(WE3_W),
    .busy_mask(busy_mask), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        q[$];
  logic [31:0] act_rf [32];
  bit   [31:0] wrote;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs, let them settle, compare against the model, record any real write.
  task automatic drive(input bit rw, input logic [4:0] rd, input logic [31:0] res,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        ew;
    logic [31:0] eb;
    RegWrite_W = rw; Rd_W = rd; Result_W = res;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    #1;
    if (rw && rd != 5'd0) begin
      ea = rd; ed = res; ew = 1'b1;
    end else if (q.size() > 0) begin
      ea = q[0].rd; ed = q[0].data; ew = q[0].live;
    end else begin
      ea = 5'd0; ed = 32'd0; ew = 1'b0;
    end
    eb = 32'd0;
    foreach (q[i]) if (q[i].live) eb[q[i].rd] = 1'b1;
    chk("a3", {27'd0, A3_W}, {27'd0, ea});
    chk("wd3", WD3_W, ed);
    chk("we3", {31'd0, WE3_W}, {31'd0, ew});
    chk("busy", busy_mask, eb);
    chk("count", {29'd0, fifo_count}, q.size());
    chk("ready", {31'd0, mdu_ready}, (q.size() < DEPTH) ? 32'd1 : 32'd0);
    chk("x0", {31'd0, WE3_W && (A3_W == 5'd0)}, 32'd0);
    if (WE3_W === 1'b1) begin
      act_rf[A3_W] = WD3_W;
      wrote[A3_W] = 1'b1;
    end
  endtask

  // Clock edge, then apply the specified state update to the model.
  task automatic tick();
    bit wsel;
    bit rdy;
    @(posedge clk);
    wsel = RegWrite_W && (Rd_W != 5'd0);
    rdy  = q.size() < DEPTH;
    if (rst_n) begin
      if (q.size() > 0 && (!wsel || !q[0].live)) void'(q.pop_front());
      if (wsel) foreach (q[i]) if (q[i].rd == Rd_W) q[i].live = 1'b0;
      if (mdu_valid && rdy && mdu_rd != 5'd0) q.push_back('{mdu_rd, mdu_data, 1'b1});
    end
    #1;
  endtask

  initial begin
    wrote = 32'd0;
    for (int i = 0; i < 32; i++) act_rf[i] = 32'd0;
    rst_n = 1'b0;
    RegWrite_W = 1'b1; Rd_W = 5'd3; Result_W = 32'h55;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;

    // Reset holds every output low even with a W-stage request.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_we3", {31'd0, WE3_W}, 32'd0);
    chk("rst_a3", {27'd0, A3_W}, 32'd0);
    chk("rst_ready", {31'd0, mdu_ready}, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", {31'd0, mdu_ready}, 32'd1);
    chk("rel_count", {29'd0, fifo_count}, 32'd0);
    @(posedge clk);
    #1;

    // W-stage pass-through.
    drive(1, 5'd5, 32'h00001234, 0, 5'd0, 32'd0);
    chk("pt_a3", {27'd0, A3_W}, 32'd5);
    chk("pt_wd3", WD3_W, 32'h00001234);
    chk("pt_we3", {31'd0, WE3_W}, 32'd1);
    tick();
    drive(1, 5'd0, 32'hFFFF, 0, 5'd0, 32'd0);
    chk("pt_x0_we3", {31'd0, WE3_W}, 32'd0);
    tick();

    // Push then drain.
    drive(0, 5'd0, 32'd0, 1, 5'd7, 32'hDEADBEEF);
    tick();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("pd_count1", {29'd0, fifo_count}, 32'd1);
    chk("pd_busy", busy_mask, 32'h00000080);
    chk("pd_we3", {31'd0, WE3_W}, 32'd1);
    chk("pd_a3", {27'd0, A3_W}, 32'd7);
    chk("pd_wd3", WD3_W, 32'hDEADBEEF);
    tick();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("pd_count0", {29'd0, fifo_count}, 32'd0);
    chk("pd_busy0", busy_mask, 32'd0);
    tick();

    // Fill while W owns the port, then drain in order.
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'd1, 32'd100 + k, 1, 5'(8 + k), 32'h100 + k);
      tick();
    end
    drive(1, 5'd1, 32'd200, 1, 5'd12, 32'h999);
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    chk("full_ready", {31'd0, mdu_ready}, 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      chk("drain_a3", {27'd0, A3_W}, 8 + k);
      chk("drain_wd3", WD3_W, 32'h100 + k);
      chk("drain_ready", {31'd0, mdu_ready}, (k >= 1) ? 32'd1 : 32'd0);
      tick();
    end
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("drain_empty", {29'd0, fifo_count}, 32'd0);
    tick();

    // Squash: a younger W write to r9 kills the queued r9 result.
    drive(1, 5'd2, 32'h22, 1, 5'd9, 32'h0000AAAA);
    tick();
    drive(1, 5'd9, 32'h0000BBBB, 0, 5'd0, 32'd0);
    chk("sq_busy_pre", {31'd0, busy_mask[9]}, 32'd1);
    tick();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("sq_busy_post", {31'd0, busy_mask[9]}, 32'd0);
    chk("sq_dead_we3", {31'd0, WE3_W}, 32'd0);
    tick();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("sq_count", {29'd0, fifo_count}, 32'd0);
    chk("sq_r9", act_rf[9], 32'h0000BBBB);
    tick();

    // x0 push is accepted but discarded.
    drive(0, 5'd0, 32'd0, 1, 5'd0, 32'h77);
    chk("x0_ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("x0_count", {29'd0, fifo_count}, 32'd0);
    chk("x0_we3", {31'd0, WE3_W}, 32'd0);
    tick();

    // Random traffic, small register range to provoke squashes.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 99) < 60, 5'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 99) < 50, 5'($urandom_range(0, 15)), $urandom);
      tick();
    end
    for (int n = 0; n < DEPTH + 2; n++) begin
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      tick();
    end

    // Reset mid-operation discards queued results.
    wrote[22:20] = 3'b000;
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'd1, 32'd300 + k, 1, 5'(20 + k), 32'hC0DE0000 + k);
      tick();
    end
    drive(1, 5'd1, 32'd400, 0, 5'd0, 32'd0);
    chk("mr_count3", {29'd0, fifo_count}, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_we3", {31'd0, WE3_W}, 32'd0);
    chk("mr_a3", {27'd0, A3_W}, 32'd0);
    chk("mr_count", {29'd0, fifo_count}, 32'd0);
    chk("mr_busy", busy_mask, 32'd0);
    chk("mr_ready", {31'd0, mdu_ready}, 32'd0);
    q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      tick();
    end
    chk("mr_never_written", {29'd0, wrote[22:20]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
